dram_arb: RTL and testbench
===========================

# dram_arb

Two-port arbiter and sequencer sharing the single core DRAM port between instruction fetch (IFU) and the load/store unit (LSU). It accepts one request at a time and drives the DRAM strobes for exactly one cycle. It waits a fixed read latency, then returns a registered response to the winning requester. It sits between the IFU/LSU and the DRAM model, and presents the same DRAM signal set the LSU previously drove directly.

## Interface
- DRAM_AW, 64, DRAM address width
- RD_LAT, 1, cycles from `o_dram_re` high to `i_dram_dout` valid; legal range 1..4

- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- ifu_req_valid  in  1  IFU read request
- ifu_req_ready  out  1  IFU request accepted this cycle
- ifu_req_addr  in  DRAM_AW  IFU address, 8-byte aligned by the arbiter
- ifu_rsp_valid  out  1  one-cycle IFU response pulse
- ifu_rsp_data  out  64  IFU read data
- lsu_req_valid  in  1  LSU request
- lsu_req_ready  out  1  LSU request accepted this cycle
- lsu_req_addr  in  DRAM_AW  LSU address, aligned by the arbiter
- lsu_req_we  in  8  byte write enables
- lsu_req_re  in  1  read enable
- lsu_req_din  in  64  write data, already lane-replicated
- lsu_rsp_valid  out  1  one-cycle LSU response pulse
- lsu_rsp_data  out  64  LSU read data; 0 for writes and no-ops
- o_dram_addr  out  DRAM_AW  `{addr[AW-1:3],3'b000}`
- o_dram_we  out  8  byte write strobes
- o_dram_re  out  1  read strobe
- o_dram_din  out  64  write data
- i_dram_dout  in  64  read data

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP. Reset state is IDLE.
- IDLE:
  - Grant is computed combinationally from the valids.
  - `*_req_ready` is high only for the granted port.
  - On handshake, latch into registers: addr, we, re, din, and owner ID. Then go to ISSUE.
  - With no valid request, remain in IDLE.
- ISSUE:
  - Drive `o_dram_*` from the latched registers for exactly one cycle.
  - Write (we≠0): `re` is forced to 0, even if requested. Next state is RESP.
  - Read (we=0, re=1): next state is WAIT, with a counter loaded to RD_LAT−1.
  - No-op (we=0, re=0): no strobe is asserted. Next state is RESP.
  - IFU requests are always reads: we=0, re=1.
- WAIT:
  - Decrement the counter each cycle.
  - When count==0, capture `i_dram_dout` into the response register and go to RESP.
- RESP:
  - Pulse `rsp_valid` for one cycle on the owner's port only, with the response register on `rsp_data`. Then go to IDLE.
  - There is no response backpressure; requesters must sink the pulse.
- Outside ISSUE, `o_dram_we`=0 and `o_dram_re`=0. `o_dram_addr` and `o_dram_din` hold their last latched values.
- `rsp_data` of the non-owner port holds its previous value.
- Only one transaction is outstanding at a time. A request arriving in a non-IDLE state waits, and `ready` stays low.
- Simultaneous valids: arbitration per Configuration.
- Reset asserted mid-transaction:
  - State goes to IDLE immediately and the transaction is dropped.
  - All strobes, readys and rsp_valids go to 0 asynchronously.

## Timing
- Reset values: all outputs 0, all registers 0, last_grant = IFU.
- Handshake at cycle T:
  - ISSUE at T+1.
  - Read: data sampled at T+1+RD_LAT. RESP at T+2+RD_LAT (RD_LAT=1 gives T+3).
  - Write or no-op: RESP at T+2.
- Next accept is no earlier than the cycle after RESP. Back-to-back read throughput is one per RD_LAT+3 cycles.
- `ready` is combinational on `valid` in IDLE. `valid` must not depend combinationally on `ready`.

## Configuration
- `DRAM_ARB_RR_EN` defined:
  - Round-robin. A 1-bit `last_grant` register is updated on each handshake.
  - On conflict, the port not granted last wins.
  - The reset value gives LSU the first conflict.
- `DRAM_ARB_RR_EN` undefined:
  - Fixed priority: LSU always wins on conflict.
  - `last_grant` is not implemented.

## Structure
- Shared package `dram_arb_pkg`:
  - State enum (IDLE/ISSUE/WAIT/RESP).
  - Owner ID constants (OWN_IFU=0, OWN_LSU=1).
  - Latency counter width derived from RD_LAT max 4 (2 bits).
- One sub-module: `dram_arb_pick`. It is a two-way grant function taking valids and `last_grant`, and emitting a one-hot grant. It contains the `DRAM_ARB_RR_EN` selection.

## Test plan
- IFU-only read, addr 0x1005, RD_LAT=1, memory word 0x1122334455667788:
  - `o_dram_addr`=0x1000 and `re`=1 at T+1 only.
  - `ifu_rsp_valid` pulse at T+3 with that data.
- LSU write, we=8'h0F, din=0xAABBCCDD_AABBCCDD:
  - `o_dram_we`=8'h0F for one cycle at T+1, `re`=0.
  - `lsu_rsp_valid` at T+2 with data 0.
- Both valid every cycle for 4 grants:
  - RR build: grant order LSU, IFU, LSU, IFU.
  - Fixed build: LSU four times, IFU ready never high.
- RD_LAT=4 read: `re` pulse at T+1, data sampled at T+5, `lsu_rsp_valid` at T+6. The other port's request is held un-readied throughout.
- `rst_n` low during WAIT:
  - Strobes and rsp_valids are 0 immediately, and no response is ever issued.
  - After release, a new request is accepted at the first edge.
- LSU request with we=8'hFF and re=1: write performed, `o_dram_re`=0, response data 0.

Source files
------------

// File: rtl/dram_arb_pkg.sv
// +--------------------------------------------------------------------+
// | dram_arb_pkg : shared states, owner IDs and latency counter width  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

package dram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam logic OWN_IFU = 1'b0;
  localparam logic OWN_LSU = 1'b1;

  localparam int RD_LAT_MAX = 4;
  localparam int LAT_W      = $clog2(RD_LAT_MAX);

endpackage

`default_nettype wire

// File: rtl/dram_arb_pick.sv
// +--------------------------------------------------------------------+
// | dram_arb_pick : two-way one-hot grant (bit0 IFU, bit1 LSU)          |
// | Macro DRAM_ARB_RR_EN selects round-robin, else LSU fixed priority  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module dram_arb_pick
  import dram_arb_pkg::*;
(
  input  logic       ifu_valid,
  input  logic       lsu_valid,
  input  logic       last_grant,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    if (ifu_valid && lsu_valid) begin
`ifdef DRAM_ARB_RR_EN
      grant = (last_grant == OWN_LSU) ? 2'b01 : 2'b10;
`else
      grant = 2'b10;
`endif
    end else if (lsu_valid) begin
      grant = 2'b10;
    end else if (ifu_valid) begin
      grant = 2'b01;
    end
  end

`ifndef DRAM_ARB_RR_EN
  logic unused_last_grant;
  assign unused_last_grant = last_grant;
`endif

endmodule

`default_nettype wire

// File: rtl/dram_arb.sv
// +--------------------------------------------------------------------+
// | dram_arb : IFU/LSU arbiter and single-outstanding DRAM sequencer   |
// | Macro DRAM_ARB_RR_EN enables round-robin arbitration               |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module dram_arb
  import dram_arb_pkg::*;
#(
  parameter int DRAM_AW = 64,
  parameter int RD_LAT  = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ifu_req_valid,
  output logic               ifu_req_ready,
  input  logic [DRAM_AW-1:0] ifu_req_addr,
  output logic               ifu_rsp_valid,
  output logic [63:0]        ifu_rsp_data,
  input  logic               lsu_req_valid,
  output logic               lsu_req_ready,
  input  logic [DRAM_AW-1:0] lsu_req_addr,
  input  logic [7:0]         lsu_req_we,
  input  logic               lsu_req_re,
  input  logic [63:0]        lsu_req_din,
  output logic               lsu_rsp_valid,
  output logic [63:0]        lsu_rsp_data,
  output logic [DRAM_AW-1:0] o_dram_addr,
  output logic [7:0]         o_dram_we,
  output logic               o_dram_re,
  output logic [63:0]        o_dram_din,
  input  logic [63:0]        i_dram_dout
);

  localparam logic [LAT_W-1:0]   LAT_LOAD   = LAT_W'(RD_LAT - 1);
  localparam logic [DRAM_AW-1:0] ALIGN_MASK = {{(DRAM_AW-3){1'b1}}, 3'b000};

  state_t             state, state_nxt;
  logic [DRAM_AW-1:0] addr_q;
  logic [7:0]         we_q;
  logic               re_q;
  logic [63:0]        din_q;
  logic               owner;
  logic [LAT_W-1:0]   cnt;
  logic [63:0]        ifu_data_q, lsu_data_q;
  logic               last_grant;
  logic [1:0]         grant;
  logic               handshake;
  logic               is_write;
  logic [DRAM_AW-1:0] sel_addr;

  dram_arb_pick u_pick (
    .ifu_valid  (ifu_req_valid),
    .lsu_valid  (lsu_req_valid),
    .last_grant (last_grant),
    .grant      (grant)
  );

  assign ifu_req_ready = (state == IDLE) && grant[0];
  assign lsu_req_ready = (state == IDLE) && grant[1];
  assign handshake     = ifu_req_ready || lsu_req_ready;
  assign is_write      = |we_q;
  assign sel_addr      = grant[1] ? lsu_req_addr : ifu_req_addr;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (handshake) state_nxt = ISSUE;
      ISSUE:   state_nxt = (!is_write && re_q) ? WAIT : RESP;
      WAIT:    if (cnt == '0) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      addr_q     <= '0;
      we_q       <= '0;
      re_q       <= 1'b0;
      din_q      <= '0;
      owner      <= OWN_IFU;
      cnt        <= '0;
      ifu_data_q <= '0;
      lsu_data_q <= '0;
    end else begin
      state <= state_nxt;
      if (handshake) begin
        addr_q <= sel_addr & ALIGN_MASK;
        owner  <= grant[1] ? OWN_LSU : OWN_IFU;
        we_q   <= grant[1] ? lsu_req_we  : 8'h00;
        re_q   <= grant[1] ? lsu_req_re  : 1'b1;
        din_q  <= grant[1] ? lsu_req_din : 64'h0;
      end
      if (state == ISSUE) begin
        cnt <= LAT_LOAD;
        // Writes and no-ops return zero data to their owner.
        if (is_write || !re_q) begin
          if (owner == OWN_LSU) lsu_data_q <= '0;
          else                  ifu_data_q <= '0;
        end
      end
      if (state == WAIT) begin
        if (cnt == '0) begin
          if (owner == OWN_LSU) lsu_data_q <= i_dram_dout;
          else                  ifu_data_q <= i_dram_dout;
        end else begin
          cnt <= cnt - 1'b1;
        end
      end
    end
  end

`ifdef DRAM_ARB_RR_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         last_grant <= OWN_IFU;
    else if (handshake) last_grant <= grant[1] ? OWN_LSU : OWN_IFU;
  end
`else
  assign last_grant = OWN_IFU;
`endif

  // Strobes are decoded from state so an async reset clears them at once.
  assign o_dram_addr   = addr_q;
  assign o_dram_din    = din_q;
  assign o_dram_we     = (state == ISSUE) ? we_q : 8'h00;
  assign o_dram_re     = (state == ISSUE) && !is_write && re_q;
  assign ifu_rsp_valid = (state == RESP) && (owner == OWN_IFU);
  assign lsu_rsp_valid = (state == RESP) && (owner == OWN_LSU);
  assign ifu_rsp_data  = ifu_data_q;
  assign lsu_rsp_data  = lsu_data_q;

endmodule

`default_nettype wire

// File: tb/tb_dram_arb.sv
// +--------------------------------------------------------------------+
// | tb_dram_arb : directed vector bench for dram_arb (RD_LAT 1 and 4)   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_dram_arb;

  localparam logic [63:0] JUNK = 64'hDEAD_BEEF_0BAD_F00D;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // RD_LAT = 1 instance
  logic        ifu_req_valid = 0, ifu_req_ready, ifu_rsp_valid;
  logic [63:0] ifu_req_addr = '0, ifu_rsp_data;
  logic        lsu_req_valid = 0, lsu_req_ready, lsu_req_re = 0, lsu_rsp_valid;
  logic [63:0] lsu_req_addr = '0, lsu_req_din = '0, lsu_rsp_data;
  logic [7:0]  lsu_req_we = '0, o_dram_we;
  logic [63:0] o_dram_addr, o_dram_din, i_dram_dout;
  logic        o_dram_re;

  // RD_LAT = 4 instance
  logic        ifu_req_valid_4 = 0, ifu_req_ready_4, ifu_rsp_valid_4;
  logic [63:0] ifu_req_addr_4 = '0, ifu_rsp_data_4;
  logic        lsu_req_valid_4 = 0, lsu_req_ready_4, lsu_req_re_4 = 0, lsu_rsp_valid_4;
  logic [63:0] lsu_req_addr_4 = '0, lsu_req_din_4 = '0, lsu_rsp_data_4;
  logic [7:0]  lsu_req_we_4 = '0, o_dram_we_4;
  logic [63:0] o_dram_addr_4, o_dram_din_4, i_dram_dout_4;
  logic        o_dram_re_4;

  dram_arb #(.DRAM_AW(64), .RD_LAT(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_req_addr(ifu_req_addr),
    .ifu_rsp_valid(ifu_rsp_valid), .ifu_rsp_data(ifu_rsp_data),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_req_addr(lsu_req_addr),
    .lsu_req_we(lsu_req_we), .lsu_req_re(lsu_req_re), .lsu_req_din(lsu_req_din),
    .lsu_rsp_valid(lsu_rsp_valid), .lsu_rsp_data(lsu_rsp_data),
    .o_dram_addr(o_dram_addr), .o_dram_we(o_dram_we), .o_dram_re(o_dram_re),
    .o_dram_din(o_dram_din), .i_dram_dout(i_dram_dout)
  );

  dram_arb #(.DRAM_AW(64), .RD_LAT(4)) dut4 (
    .clk(clk), .rst_n(rst_n),
    .ifu_req_valid(ifu_req_valid_4), .ifu_req_ready(ifu_req_ready_4), .ifu_req_addr(ifu_req_addr_4),
    .ifu_rsp_valid(ifu_rsp_valid_4), .ifu_rsp_data(ifu_rsp_data_4),
    .lsu_req_valid(lsu_req_valid_4), .lsu_req_ready(lsu_req_ready_4), .lsu_req_addr(lsu_req_addr_4),
    .lsu_req_we(lsu_req_we_4), .lsu_req_re(lsu_req_re_4), .lsu_req_din(lsu_req_din_4),
    .lsu_rsp_valid(lsu_rsp_valid_4), .lsu_rsp_data(lsu_rsp_data_4),
    .o_dram_addr(o_dram_addr_4), .o_dram_we(o_dram_we_4), .o_dram_re(o_dram_re_4),
    .o_dram_din(o_dram_din_4), .i_dram_dout(i_dram_dout_4)
  );

  function automatic logic [63:0] mem(input logic [63:0] a);
    return (a == 64'h1000) ? 64'h1122334455667788 : {a[31:0], ~a[31:0]};
  endfunction

  // DRAM models: data is valid only in the single cycle RD_LAT after re.
  logic [3:0]  pipe1 = '0, pipe4 = '0;
  logic [63:0] rd_addr1 = '0, rd_addr4 = '0;
  always @(posedge clk) begin
    pipe1 <= {pipe1[2:0], o_dram_re};
    pipe4 <= {pipe4[2:0], o_dram_re_4};
    if (o_dram_re)   rd_addr1 <= o_dram_addr;
    if (o_dram_re_4) rd_addr4 <= o_dram_addr_4;
  end
  assign i_dram_dout   = pipe1[0] ? mem(rd_addr1) : JUNK;
  assign i_dram_dout_4 = pipe4[3] ? mem(rd_addr4) : JUNK;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  typedef struct {
    logic        lsu;
    logic [63:0] addr;
    logic [7:0]  we;
    logic        re;
    logic [63:0] din;
    logic [63:0] exp_addr;
    logic [7:0]  exp_we;
    logic        exp_re;
    logic [63:0] exp_data;
    int          exp_cyc;
  } vec_t;

  logic [63:0] exp_ifu = '0, exp_lsu = '0;

  // Call at a negedge; handshake happens at the following posedge.
  task automatic run_vec(input vec_t v);
    if (v.lsu) begin
      lsu_req_valid = 1; lsu_req_addr = v.addr; lsu_req_we = v.we;
      lsu_req_re = v.re; lsu_req_din = v.din;
    end else begin
      ifu_req_valid = 1; ifu_req_addr = v.addr;
    end
    #1;
    chk("ready", 64'({ifu_req_ready, lsu_req_ready}), v.lsu ? 64'd1 : 64'd2);
    @(posedge clk);
    @(negedge clk);
    ifu_req_valid = 0; lsu_req_valid = 0;
    #1;
    chk("issue_addr", o_dram_addr, v.exp_addr);
    chk("issue_we", 64'(o_dram_we), 64'(v.exp_we));
    chk("issue_re", 64'(o_dram_re), 64'(v.exp_re));
    chk("issue_busy", 64'({ifu_req_ready, lsu_req_ready, ifu_rsp_valid, lsu_rsp_valid}), 64'd0);
    for (int k = 2; k <= v.exp_cyc; k++) begin
      @(negedge clk); #1;
      if (k == v.exp_cyc) begin
        if (v.lsu) exp_lsu = v.exp_data; else exp_ifu = v.exp_data;
        chk("rsp_valid", 64'({ifu_rsp_valid, lsu_rsp_valid}), v.lsu ? 64'd1 : 64'd2);
        chk("ifu_rsp_data", ifu_rsp_data, exp_ifu);
        chk("lsu_rsp_data", lsu_rsp_data, exp_lsu);
      end else begin
        chk("wait_quiet", 64'({o_dram_we, o_dram_re, ifu_rsp_valid, lsu_rsp_valid}), 64'd0);
      end
    end
    @(negedge clk); #1;
    chk("post_rsp", 64'({ifu_rsp_valid, lsu_rsp_valid}), 64'd0);
  endtask

  vec_t vecs[6];
  bit   got;

  initial begin
    vecs[0] = '{1'b0, 64'h1005,   8'h00, 1'b1, 64'h0, 64'h1000,   8'h00, 1'b1, 64'h1122334455667788, 3};
    vecs[1] = '{1'b1, 64'h2013,   8'h0F, 1'b0, 64'hAABBCCDD_AABBCCDD, 64'h2010, 8'h0F, 1'b0, 64'h0, 2};
    vecs[2] = '{1'b1, 64'h3008,   8'h00, 1'b1, 64'h0, 64'h3008,   8'h00, 1'b1, 64'h00003008_FFFFCFF7, 3};
    vecs[3] = '{1'b1, 64'h0040,   8'hFF, 1'b1, 64'h0123456789ABCDEF, 64'h0040, 8'hFF, 1'b0, 64'h0, 2};
    vecs[4] = '{1'b1, 64'h0077,   8'h00, 1'b0, 64'h0, 64'h0070,   8'h00, 1'b0, 64'h0, 2};
    vecs[5] = '{1'b0, 64'hABCDEF, 8'h00, 1'b1, 64'h0, 64'hABCDE8, 8'h00, 1'b1, 64'h00ABCDE8_FF543217, 3};

    #2;
    chk("rst_strobes", 64'({o_dram_we, o_dram_re, ifu_rsp_valid, lsu_rsp_valid, ifu_req_ready, lsu_req_ready}), 64'd0);
    chk("rst_addr", o_dram_addr, 64'h0);
    chk("rst_din", o_dram_din, 64'h0);
    chk("rst_data", ifu_rsp_data | lsu_rsp_data, 64'h0);

    @(negedge clk); @(negedge clk);
    rst_n = 1;
    @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      run_vec(vecs[i]);
      @(negedge clk);
    end
    chk("write_din", o_dram_din, 64'h0);

    // Conflict: both ports valid continuously for four grants.
    ifu_req_valid = 1; ifu_req_addr = 64'h100;
    lsu_req_valid = 1; lsu_req_addr = 64'h200; lsu_req_we = 8'h00; lsu_req_re = 0;
    for (int g = 0; g < 4; g++) begin
      got = 0;
      for (int c = 0; c < 20 && !got; c++) begin
        #1;
        if (ifu_req_ready || lsu_req_ready) got = 1;
        else @(negedge clk);
      end
      if (!got) begin
        n_cmp++; n_err++;
        $display("FAIL arb_timeout: got no ready expected grant %0d", g);
      end else begin
`ifdef DRAM_ARB_RR_EN
        chk("arb_grant", 64'({ifu_req_ready, lsu_req_ready}), (g % 2 == 0) ? 64'd1 : 64'd2);
`else
        chk("arb_grant", 64'({ifu_req_ready, lsu_req_ready}), 64'd1);
`endif
        @(negedge clk);
      end
    end
    ifu_req_valid = 0; lsu_req_valid = 0;
    repeat (6) @(negedge clk);
    exp_lsu = 64'h0;
`ifdef DRAM_ARB_RR_EN
    exp_ifu = mem(64'h100);
`endif
    chk("arb_ifu_data", ifu_rsp_data, exp_ifu);

    // RD_LAT = 4 read with IFU held waiting.
    ifu_req_valid_4 = 1; ifu_req_addr_4 = 64'h600;
    lsu_req_valid_4 = 1; lsu_req_addr_4 = 64'h505; lsu_req_we_4 = 8'h00; lsu_req_re_4 = 1;
    #1;
    chk("lat4_ready", 64'({ifu_req_ready_4, lsu_req_ready_4}), 64'd1);
    @(posedge clk); @(negedge clk);
    lsu_req_valid_4 = 0;
    for (int k = 1; k <= 6; k++) begin
      #1;
      chk("lat4_ifu_ready", 64'(ifu_req_ready_4), 64'd0);
      chk("lat4_re", 64'(o_dram_re_4), (k == 1) ? 64'd1 : 64'd0);
      chk("lat4_rsp_valid", 64'({ifu_rsp_valid_4, lsu_rsp_valid_4}), (k == 6) ? 64'd1 : 64'd0);
      if (k == 1) chk("lat4_addr", o_dram_addr_4, 64'h500);
      if (k == 6) chk("lat4_data", lsu_rsp_data_4, mem(64'h500));
      else @(negedge clk);
    end
    ifu_req_valid_4 = 0;
    repeat (3) @(negedge clk);

    // Reset during WAIT drops the transaction.
    ifu_req_valid = 1; ifu_req_addr = 64'h1005;
    @(posedge clk); @(negedge clk);
    ifu_req_valid = 0;
    #1;
    chk("rstw_issue_re", 64'(o_dram_re), 64'd1);
    @(negedge clk);
    rst_n = 0;
    #1;
    chk("rstw_strobes", 64'({o_dram_we, o_dram_re, ifu_rsp_valid, lsu_rsp_valid, ifu_req_ready, lsu_req_ready}), 64'd0);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk); #1;
      chk("rstw_quiet", 64'({ifu_rsp_valid, lsu_rsp_valid}), 64'd0);
      chk("rstw_data", ifu_rsp_data, 64'h0);
    end
    exp_ifu = 64'h0; exp_lsu = 64'h0;
    @(negedge clk);
    rst_n = 1;
    run_vec(vecs[2]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
